// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one block-wide memory port between icache (read) and dcache (read/write-back)
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_BLOCK_ADDR,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_BLOCK_ADDR,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_BLOCK_ADDR,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic               ERROR
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic req_i, req_d, pick_d, gnt_d, last_d, op_wr, timeout_hit, finish;
  logic [ADDR_W-1:0] addr_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic [15:0] cnt;
  assign req_i = I_READ;
  assign req_d = D_READ | D_WRITE;
  // dcache wins unless both request and it was the last one served
  assign pick_d = req_d && !(req_i && last_d);
  assign timeout_hit = MEM_BUSYWAIT && (cnt + 16'd1 == 16'(TIMEOUT_CYCLES));
  assign finish = state == WAIT && (!MEM_BUSYWAIT || timeout_hit);
  always_comb begin
    state_n = state == IDLE ? ((req_i || req_d) ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT ? (finish ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else state <= state_n;
  end
  assign MEM_READ = (state == ISSUE || state == WAIT) && !op_wr;
  assign MEM_WRITE = (state == ISSUE || state == WAIT) && op_wr;
  assign MEM_BLOCK_ADDR = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign I_BUSYWAIT = req_i && !(state == DONE && !gnt_d);
  assign D_BUSYWAIT = req_d && !(state == DONE && gnt_d);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gnt_d <= 1'b0;
      last_d <= 1'b0;
      op_wr <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      ERROR <= 1'b0;
      I_READDATA <= '0;
      D_READDATA <= '0;
    end else begin
      if (state == IDLE && (req_i || req_d)) begin
        gnt_d <= pick_d;
        last_d <= pick_d;
        op_wr <= pick_d && D_WRITE;
        addr_q <= pick_d ? D_BLOCK_ADDR : I_BLOCK_ADDR;
        wdata_q <= D_WRITEDATA;
      end
      cnt <= (state == WAIT && !finish) ? cnt + 16'd1 : '0;
      if (finish) begin
        if (MEM_BUSYWAIT) ERROR <= 1'b1;
        if (!op_wr && gnt_d) D_READDATA <= MEM_BUSYWAIT ? '0 : MEM_READDATA;
        if (!op_wr && !gnt_d) I_READDATA <= MEM_BUSYWAIT ? '0 : MEM_READDATA;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, transaction-timeline model checked every cycle, plus literal checks
module tb_mem_port_arbiter;
  localparam int TO = 8;
  logic CLK = 0;
  logic RESET = 1;
  logic I_READ = 0, D_READ = 0, D_WRITE = 0, MEM_BUSYWAIT;
  logic [27:0] I_BLOCK_ADDR = '0, D_BLOCK_ADDR = '0, MEM_BLOCK_ADDR;
  logic [127:0] D_WRITEDATA = '0, I_READDATA, D_READDATA, MEM_WRITEDATA, MEM_READDATA;
  logic I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, ERROR;
  int n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.ADDR_W(28), .BLOCK_W(128), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_BLOCK_ADDR(I_BLOCK_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_BLOCK_ADDR(D_BLOCK_ADDR), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .ERROR(ERROR)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int a);
    return {4{8'hC3, 24'(a)}};
  endfunction

  // memory environment: busy for mem_lat cycles after the command cycle, or forever when stuck
  int mem_lat = 5;
  bit stuck = 0;
  int mem_cnt = 0;
  logic [127:0] mem [256];
  logic [127:0] exp_mem [256];
  initial for (int i = 0; i < 256; i++) begin
    mem[i] = (i == 16) ? {8{16'hAAAA}} : pat(i);
    exp_mem[i] = mem[i];
  end
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (stuck || mem_cnt <= mem_lat);
  assign MEM_READDATA = mem[MEM_BLOCK_ADDR[7:0]];
  always @(posedge CLK or posedge RESET) begin
    if (RESET) mem_cnt <= 0;
    else begin
      if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_BLOCK_ADDR[7:0]] <= MEM_WRITEDATA;
      mem_cnt <= (MEM_READ || MEM_WRITE) ? mem_cnt + 1 : 0;
    end
  end

  // model: a granted transaction is a timeline of age 1 (command issued), ages 2..1+wl (memory waiting),
  // age 2+wl (done), with wl known at grant time from the memory latency
  int m_own = 0, m_age = 0, m_wl = 0, m_last = 1;
  bit m_w = 0, m_to = 0, m_err = 0;
  logic [27:0] m_addr = '0;
  logic [127:0] m_wd = '0, m_ird = '0, m_drd = '0;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_own = 0; m_age = 0; m_last = 1; m_err = 0; m_ird = '0; m_drd = '0;
    end else if (m_own != 0) begin
      if (m_age == 1 + m_wl) begin
        if (m_to) m_err = 1;
        if (m_w && !m_to) exp_mem[m_addr[7:0]] = m_wd;
        if (!m_w && m_own == 2) m_drd = m_to ? '0 : exp_mem[m_addr[7:0]];
        if (!m_w && m_own == 1) m_ird = m_to ? '0 : exp_mem[m_addr[7:0]];
      end
      m_age++;
      if (m_age > 2 + m_wl) m_own = 0;
    end else if (I_READ || D_READ || D_WRITE) begin
      int lat;
      m_own = (I_READ && (D_READ || D_WRITE)) ? (m_last == 1 ? 2 : 1) : (I_READ ? 1 : 2);
      m_last = m_own;
      m_w = m_own == 2 && D_WRITE;
      m_addr = m_own == 2 ? D_BLOCK_ADDR : I_BLOCK_ADDR;
      m_wd = D_WRITEDATA;
      lat = stuck ? 100000 : mem_lat;
      m_wl = (lat + 1 < TO) ? lat + 1 : TO;
      m_to = lat >= TO;
      m_age = 1;
    end
  end

  always @(negedge CLK) begin
    bit cmd, done;
    cmd = m_own != 0 && m_age <= 1 + m_wl;
    done = m_own != 0 && m_age == 2 + m_wl;
    check("mem_read", 128'(MEM_READ), 128'(cmd && !m_w));
    check("mem_write", 128'(MEM_WRITE), 128'(cmd && m_w));
    if (cmd) check("mem_addr", 128'(MEM_BLOCK_ADDR), 128'(m_addr));
    if (cmd && m_w) check("mem_wdata", MEM_WRITEDATA, m_wd);
    check("i_busywait", 128'(I_BUSYWAIT), 128'(I_READ && !(done && m_own == 1)));
    check("d_busywait", 128'(D_BUSYWAIT), 128'((D_READ || D_WRITE) && !(done && m_own == 2)));
    check("i_readdata", I_READDATA, m_ird);
    check("d_readdata", D_READDATA, m_drd);
    check("error", 128'(ERROR), 128'(m_err));
  end

  // log of issued commands as {write, address}
  logic [28:0] issues [$];
  bit prev_cmd = 0;
  always @(negedge CLK) begin
    if ((MEM_READ || MEM_WRITE) && !prev_cmd) issues.push_back({MEM_WRITE, MEM_BLOCK_ADDR});
    prev_cmd = MEM_READ || MEM_WRITE;
  end

  task automatic wait_done(input bit is_d, output int ncmd);
    ncmd = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (MEM_READ || MEM_WRITE) ncmd++;
      if (is_d ? !D_BUSYWAIT : !I_BUSYWAIT) break;
    end
    check("done_seen", 128'(is_d ? D_BUSYWAIT : I_BUSYWAIT), 128'(0));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    RESET = 0;
    tick();
    // single dcache read with 5-cycle memory busy period
    D_READ = 1; D_BLOCK_ADDR = 28'h10;
    wait_done(1, n);
    check("t1_cmd_cycles", 128'(n), 128'(7));
    check("t1_d_readdata", D_READDATA, {8{16'hAAAA}});
    check("t1_i_readdata", I_READDATA, 128'(0));
    tick();
    D_READ = 0;
    repeat (2) tick();
    // simultaneous requests right after reset: dcache first
    RESET = 1;
    #2 check("rst_mem_addr", 128'(MEM_BLOCK_ADDR), 128'(0));
    repeat (2) tick();
    issues.delete();
    I_READ = 1; I_BLOCK_ADDR = 28'h4;
    D_WRITE = 1; D_BLOCK_ADDR = 28'h8; D_WRITEDATA = 128'h1234;
    RESET = 0;
    wait_done(1, n);
    tick();
    D_WRITE = 0;
    wait_done(0, n);
    tick();
    I_READ = 0;
    check("t2_first", 128'(issues[0]), 128'({1'b1, 28'h8}));
    check("t2_second", 128'(issues[1]), 128'({1'b0, 28'h4}));
    repeat (2) tick();
    // both requesting continuously: grants alternate starting with dcache
    issues.delete();
    I_READ = 1; I_BLOCK_ADDR = 28'h34;
    D_READ = 1; D_BLOCK_ADDR = 28'h30;
    for (int k = 0; k < 300 && issues.size() < 4; k++) tick();
    check("t3_count", 128'(issues.size()), 128'(4));
    I_READ = 0; D_READ = 0;
    repeat (12) tick();
    check("t3_g0", 128'(issues[0]), 128'({1'b0, 28'h30}));
    check("t3_g1", 128'(issues[1]), 128'({1'b0, 28'h34}));
    check("t3_g2", 128'(issues[2]), 128'({1'b0, 28'h30}));
    check("t3_g3", 128'(issues[3]), 128'({1'b0, 28'h34}));
    // write-back then refill, then read back the written block
    D_WRITE = 1; D_BLOCK_ADDR = 28'h20; D_WRITEDATA = {4{32'hDEADBEEF}};
    wait_done(1, n);
    tick();
    D_WRITE = 0;
    tick();
    D_READ = 1; D_BLOCK_ADDR = 28'h40;
    wait_done(1, n);
    check("t4_refill", D_READDATA, pat(64));
    tick();
    D_READ = 0;
    tick();
    D_READ = 1; D_BLOCK_ADDR = 28'h20;
    wait_done(1, n);
    check("t4_readback", D_READDATA, {4{32'hDEADBEEF}});
    tick();
    D_READ = 0;
    tick();
    // asynchronous reset in the middle of an icache read
    issues.delete();
    I_READ = 1; I_BLOCK_ADDR = 28'h50;
    repeat (3) @(negedge CLK);
    #2 RESET = 1;
    #1 check("t5_async_mem_read", 128'(MEM_READ), 128'(0));
    check("t5_async_busy", 128'(I_BUSYWAIT), 128'(1));
    tick();
    RESET = 0;
    wait_done(0, n);
    check("t5_reissue", 128'(issues[issues.size() - 1]), 128'({1'b0, 28'h50}));
    check("t5_i_readdata", I_READDATA, pat(80));
    tick();
    I_READ = 0;
    tick();
    // stuck memory: timeout after TO wait cycles, sticky error
    stuck = 1;
    D_READ = 1; D_BLOCK_ADDR = 28'h60;
    wait_done(1, n);
    check("t6_cmd_cycles", 128'(n), 128'(1 + TO));
    check("t6_error", 128'(ERROR), 128'(1));
    check("t6_d_readdata", D_READDATA, 128'(0));
    tick();
    D_READ = 0; stuck = 0;
    tick();
    D_READ = 1; D_BLOCK_ADDR = 28'h10;
    wait_done(1, n);
    check("t6_after_data", D_READDATA, {8{16'hAAAA}});
    check("t6_error_sticky", 128'(ERROR), 128'(1));
    tick();
    D_READ = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
